// File: rtl/global_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : global_buffer_pkg
//  Purpose  : Shared types and constants for the global-buffer tile, including
//             the CGRA config packet, the parallel-config skid entry and the
//             parallel-config scheduler state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package global_buffer_pkg;

    localparam int CGRA_PER_GLB        = 4;
    localparam int CGRA_CFG_ADDR_WIDTH = 32;
    localparam int CGRA_CFG_DATA_WIDTH = 32;
    localparam int NUM_CGRA_TILES      = 32;

    typedef struct packed {
        logic                           rd_en;
        logic                           wr_en;
        logic [CGRA_CFG_ADDR_WIDTH-1:0] addr;
        logic [CGRA_CFG_DATA_WIDTH-1:0] data;
    } cgra_cfg_t;

    // One buffered DMA config request; addr already carries the tile offset.
    typedef struct packed {
        logic [CGRA_CFG_ADDR_WIDTH-1:0] addr;
        logic [CGRA_CFG_DATA_WIDTH-1:0] data;
        logic                           last;
    } pcfg_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } pcfg_sched_state_e;

endpackage
`default_nettype wire

// File: rtl/glb_pcfg_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : glb_pcfg_skid_fifo
//  Purpose  : 2-entry skid FIFO for DMA parallel-config requests.
//             Simultaneous push and pop leave the occupancy unchanged.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             i_push/i_data - write strobe and entry (ignored when full)
//             i_pop         - read strobe (ignored when empty)
//             o_data        - head entry (valid when o_count != 0)
//             o_count       - current occupancy, 0..2
//  Revision : 1.0 - initial release
// ============================================================================
module glb_pcfg_skid_fifo
    import global_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  pcfg_entry_t i_data,
    input  logic        i_pop,
    output pcfg_entry_t o_data,
    output logic [1:0]  o_count
);

    pcfg_entry_t r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        w_push;
    logic        w_pop;

    assign w_push = i_push & (r_count != 2'd2);
    assign w_pop  = i_pop  & (r_count != 2'd0);

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/glb_tile_pcfg_sched.sv
`default_nettype none
// ============================================================================
//  Module   : glb_tile_pcfg_sched
//  Purpose  : Per-tile parallel-config scheduler. Merges the JTAG config path
//             (highest priority, no backpressure, read-address bypass) and
//             the DMA parallel-config stream (valid/ready, tile offset added,
//             programmable inter-write gap) onto one registered config bus
//             broadcast to every CGRA column of the tile.
//  Ports    : clk, reset                 - clock, synchronous active-high reset
//             cfg_pc_dma_mode/offset/gap - DMA path configuration
//             jtag_cfg, jtag_*_bypass    - JTAG config source
//             pc_req_*                   - DMA request handshake and payload
//             cgra_cfg_g2f               - registered config fan-out
//             pc_busy/done_pulse/wr_cnt  - DMA sequence status
//  Revision : 1.0 - initial release
// ============================================================================
module glb_tile_pcfg_sched
    import global_buffer_pkg::*;
#(
    parameter int CGRA_PER_GLB = global_buffer_pkg::CGRA_PER_GLB,
    parameter int ADDR_W       = global_buffer_pkg::CGRA_CFG_ADDR_WIDTH,
    parameter int DATA_W       = global_buffer_pkg::CGRA_CFG_DATA_WIDTH,
    parameter int OFFSET_W     = $clog2(global_buffer_pkg::NUM_CGRA_TILES),
    parameter int GAP_W        = 4,
    parameter int CNT_W        = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_pc_dma_mode,
    input  logic [OFFSET_W-1:0]            cfg_pc_offset,
    input  logic [GAP_W-1:0]               cfg_pc_wr_gap,
    input  cgra_cfg_t                      jtag_cfg,
    input  logic                           jtag_rd_en_bypass,
    input  logic [ADDR_W-1:0]              jtag_addr_bypass,
    input  logic                           pc_req_valid,
    output logic                           pc_req_ready,
    input  logic [ADDR_W-1:0]              pc_req_addr,
    input  logic [DATA_W-1:0]              pc_req_data,
    input  logic                           pc_req_last,
    output cgra_cfg_t [CGRA_PER_GLB-1:0]   cgra_cfg_g2f,
    output logic                           pc_busy,
    output logic                           pc_done_pulse,
    output logic [CNT_W-1:0]               pc_wr_cnt
);

    pcfg_sched_state_e r_state, w_state_nxt;
    logic [GAP_W-1:0]  r_gap;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_base;
    logic              r_done;
    cgra_cfg_t         r_cfg;

    cgra_cfg_t         w_jtag_pkt;
    logic              w_jtag_act;
    cgra_cfg_t         w_issue;
    pcfg_entry_t       w_head;
    pcfg_entry_t       w_push_entry;
    logic [1:0]        w_count;
    logic [1:0]        w_count_nxt;
    logic              w_push;
    logic              w_pop;

    // ---------------- JTAG source select ----------------
    always_comb begin
        w_jtag_pkt = jtag_cfg;
        if (jtag_rd_en_bypass) begin
            w_jtag_pkt       = '0;
            w_jtag_pkt.rd_en = 1'b1;
            w_jtag_pkt.addr  = jtag_addr_bypass;
        end
    end
    assign w_jtag_act = w_jtag_pkt.rd_en | w_jtag_pkt.wr_en;

    // ---------------- DMA skid buffer ----------------
    // Ready is held low during reset so nothing is accepted into a FIFO
    // that is being cleared.
    assign pc_req_ready = cfg_pc_dma_mode & (w_count != 2'd2) & ~reset;
    assign w_push       = pc_req_valid & pc_req_ready;

    // Offset is applied at accept time, so a later offset change only
    // affects requests accepted after it. The sum wraps at ADDR_W bits.
    assign w_push_entry.addr = pc_req_addr + {{(ADDR_W-OFFSET_W){1'b0}}, cfg_pc_offset};
    assign w_push_entry.data = pc_req_data;
    assign w_push_entry.last = pc_req_last;

    glb_pcfg_skid_fifo u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    // ---------------- Arbitration ----------------
    assign w_pop       = ~w_jtag_act & (w_count != 2'd0) & (r_gap == '0);
    assign w_count_nxt = w_count + {1'b0, w_push} - {1'b0, w_pop};

    always_comb begin
        w_issue = '0;
        if (w_jtag_act) begin
            w_issue = w_jtag_pkt;
        end else if (w_pop) begin
            w_issue.wr_en = 1'b1;
            w_issue.addr  = w_head.addr;
            w_issue.data  = w_head.data;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // "Entries remain" looks at the post-cycle occupancy so a push landing
    // in the same cycle keeps the scheduler out of IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_push) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_pop) begin
                    if (cfg_pc_wr_gap != '0) begin
                        w_state_nxt = GAP;
                    end else if (w_count_nxt == 2'd0) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (r_gap == {{(GAP_W-1){1'b0}}, 1'b1}) begin
                    w_state_nxt = (w_count_nxt != 2'd0) ? ISSUE : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pc_busy = (r_state != IDLE);
    end

    // ---------------- Gap counter, write counter, output register ----------------
    // The write count restarts in the cycle after a done pulse; a pop in that
    // same cycle counts as the first write of the next sequence.
    assign w_cnt_base = r_done ? '0 : r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_cfg  <= '0;
        end else begin
            if (w_pop) begin
                r_gap <= cfg_pc_wr_gap;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - {{(GAP_W-1){1'b0}}, 1'b1};
            end
            if (w_pop && (w_cnt_base != '1)) begin
                r_cnt <= w_cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= w_cnt_base;
            end
            r_done <= w_pop & w_head.last;
            r_cfg  <= w_issue;
        end
    end

    assign pc_done_pulse = r_done;
    assign pc_wr_cnt     = r_cnt;

    generate
        for (genvar gi = 0; gi < CGRA_PER_GLB; gi++) begin : g_fanout
            assign cgra_cfg_g2f[gi] = r_cfg;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_glb_tile_pcfg_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glb_tile_pcfg_sched
//  Purpose  : Self-checking bench for glb_tile_pcfg_sched: vector tables for
//             the JTAG path and address offset, hand sequences for the
//             multi-cycle cases, and randomized traffic against a queue-based
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_glb_tile_pcfg_sched;
    import global_buffer_pkg::*;

    logic        clk;
    logic        reset;
    logic        cfg_pc_dma_mode;
    logic [4:0]  cfg_pc_offset;
    logic [3:0]  cfg_pc_wr_gap;
    cgra_cfg_t   jtag_cfg;
    logic        jtag_rd_en_bypass;
    logic [31:0] jtag_addr_bypass;
    logic        pc_req_valid;
    logic        pc_req_ready;
    logic [31:0] pc_req_addr;
    logic [31:0] pc_req_data;
    logic        pc_req_last;
    cgra_cfg_t [3:0] cgra_cfg_g2f;
    logic        pc_busy;
    logic        pc_done_pulse;
    logic [15:0] pc_wr_cnt;

    glb_tile_pcfg_sched dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_pc_dma_mode   (cfg_pc_dma_mode),
        .cfg_pc_offset     (cfg_pc_offset),
        .cfg_pc_wr_gap     (cfg_pc_wr_gap),
        .jtag_cfg          (jtag_cfg),
        .jtag_rd_en_bypass (jtag_rd_en_bypass),
        .jtag_addr_bypass  (jtag_addr_bypass),
        .pc_req_valid      (pc_req_valid),
        .pc_req_ready      (pc_req_ready),
        .pc_req_addr       (pc_req_addr),
        .pc_req_data       (pc_req_data),
        .pc_req_last       (pc_req_last),
        .cgra_cfg_g2f      (cgra_cfg_g2f),
        .pc_busy           (pc_busy),
        .pc_done_pulse     (pc_done_pulse),
        .pc_wr_cnt         (pc_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } ment_t;

    ment_t     q[$];
    int        m_gap;
    cgra_cfg_t m_out;
    logic      m_done;
    int        m_cnt;
    logic      m_busy;
    int        n_tests;
    int        n_fail;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        pc_req_valid      = 1'b0;
        pc_req_last       = 1'b0;
        jtag_cfg          = '0;
        jtag_rd_en_bypass = 1'b0;
    endtask

    // One clock cycle: check ready, advance the model, check registered outputs.
    task automatic step();
        cgra_cfg_t jp;
        ment_t     e;
        logic      acc;
        logic      pop;
        #1;
        check("ready", pc_req_ready, (cfg_pc_dma_mode && q.size() < 2));
        acc = pc_req_valid && cfg_pc_dma_mode && (q.size() < 2);
        if (jtag_rd_en_bypass) begin
            jp = '0;
            jp.rd_en = 1'b1;
            jp.addr  = jtag_addr_bypass;
        end else begin
            jp = jtag_cfg;
        end
        pop = 1'b0;
        e   = '0;
        if (m_done) m_cnt = 0;
        m_out = '0;
        if (jp.rd_en || jp.wr_en) begin
            m_out = jp;
        end else if (q.size() > 0 && m_gap == 0) begin
            e = q.pop_front();
            pop = 1'b1;
            m_out.wr_en = 1'b1;
            m_out.addr  = e.addr;
            m_out.data  = e.data;
        end
        if (pop) m_gap = int'(cfg_pc_wr_gap);
        else if (m_gap > 0) m_gap--;
        if (acc) q.push_back('{addr: pc_req_addr + 32'(cfg_pc_offset), data: pc_req_data, last: pc_req_last});
        m_done = pop && e.last;
        if (pop && m_cnt < 65535) m_cnt++;
        m_busy = (q.size() > 0) || (m_gap > 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check("g2f_lane", cgra_cfg_g2f[i], m_out);
        check("busy", pc_busy, m_busy);
        check("done", pc_done_pulse, m_done);
        check("wr_cnt", pc_wr_cnt, 66'(m_cnt));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        pc_req_valid    = 1'b1;
        cfg_pc_dma_mode = 1'b1;
        #1;
        check("rst_ready", pc_req_ready, 66'd0);
        @(posedge clk);
        #1;
        check("rst_g2f", cgra_cfg_g2f, 264'd0 == 264'(cgra_cfg_g2f) ? 66'(cgra_cfg_g2f) : 66'h1);
        check("rst_lane0", cgra_cfg_g2f[0], 66'd0);
        check("rst_busy", pc_busy, 66'd0);
        check("rst_done", pc_done_pulse, 66'd0);
        check("rst_cnt", pc_wr_cnt, 66'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        q.delete();
        m_gap = 0; m_out = '0; m_done = 1'b0; m_cnt = 0; m_busy = 1'b0;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic l);
        pc_req_valid = 1'b1;
        pc_req_addr  = a;
        pc_req_data  = d;
        pc_req_last  = l;
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        cgra_cfg_t   jcfg;
        logic        byp;
        logic [31:0] baddr;
        cgra_cfg_t   exp;
    } jvec_t;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  off;
        logic [31:0] exp;
    } avec_t;

    jvec_t jv[5];
    avec_t av[4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cfg_pc_offset    = 5'd0;
        cfg_pc_wr_gap    = 4'd0;
        jtag_addr_bypass = 32'd0;
        pc_req_addr      = 32'd0;
        pc_req_data      = 32'd0;
        idle_inputs();

        jv[0] = '{jcfg: '{rd_en: 1'b0, wr_en: 1'b1, addr: 32'hAB, data: 32'h12345678}, byp: 1'b0, baddr: 32'h0,
                  exp: '{rd_en: 1'b0, wr_en: 1'b1, addr: 32'hAB, data: 32'h12345678}};
        jv[1] = '{jcfg: '{rd_en: 1'b0, wr_en: 1'b1, addr: 32'hAB, data: 32'h1}, byp: 1'b1, baddr: 32'h55,
                  exp: '{rd_en: 1'b1, wr_en: 1'b0, addr: 32'h55, data: 32'h0}};
        jv[2] = '{jcfg: '{rd_en: 1'b1, wr_en: 1'b0, addr: 32'h77, data: 32'hDEAD}, byp: 1'b0, baddr: 32'h9,
                  exp: '{rd_en: 1'b1, wr_en: 1'b0, addr: 32'h77, data: 32'hDEAD}};
        jv[3] = '{jcfg: '{rd_en: 1'b0, wr_en: 1'b0, addr: 32'h33, data: 32'h44}, byp: 1'b0, baddr: 32'h9,
                  exp: '{rd_en: 1'b0, wr_en: 1'b0, addr: 32'h0, data: 32'h0}};
        jv[4] = '{jcfg: '{rd_en: 1'b0, wr_en: 1'b0, addr: 32'h0, data: 32'h0}, byp: 1'b1, baddr: 32'hFFFF0000,
                  exp: '{rd_en: 1'b1, wr_en: 1'b0, addr: 32'hFFFF0000, data: 32'h0}};

        av[0] = '{addr: 32'hFFFFFFF0, off: 5'd31, exp: 32'h0000000F};
        av[1] = '{addr: 32'h00000010, off: 5'd3,  exp: 32'h00000013};
        av[2] = '{addr: 32'hFFFFFFFF, off: 5'd1,  exp: 32'h00000000};
        av[3] = '{addr: 32'h7FFFFFFF, off: 5'd16, exp: 32'h8000000F};

        // 1. reset with valid held high
        do_reset();
        #1;
        check("post_rst_ready", pc_req_ready, 66'd1);
        @(negedge clk);

        // 2. three back-to-back requests, offset 3, no gap
        cfg_pc_offset = 5'd3;
        push_req(32'h10, 32'hA0, 1'b0); step();
        push_req(32'h20, 32'hA1, 1'b0); step();
        check("t2_addr0", {cgra_cfg_g2f[3].wr_en, cgra_cfg_g2f[3].addr}, {1'b1, 32'h13});
        push_req(32'h30, 32'hA2, 1'b1); step();
        check("t2_addr1", {cgra_cfg_g2f[0].wr_en, cgra_cfg_g2f[0].addr}, {1'b1, 32'h23});
        idle_inputs(); step();
        check("t2_addr2", {cgra_cfg_g2f[1].wr_en, cgra_cfg_g2f[1].addr}, {1'b1, 32'h33});
        check("t2_done", pc_done_pulse, 66'd1);
        check("t2_cnt3", pc_wr_cnt, 66'd3);
        step();
        check("t2_cnt0", pc_wr_cnt, 66'd0);

        // mid-sequence reset drops pending entries
        jtag_cfg.wr_en = 1'b1;
        push_req(32'h70, 32'h1, 1'b0); step();
        push_req(32'h74, 32'h2, 1'b1); step();
        do_reset();
        step();
        check("mid_rst_out", cgra_cfg_g2f[0], 66'd0);
        check("mid_rst_busy", pc_busy, 66'd0);

        // 3. gap of 2 between two issues
        cfg_pc_offset = 5'd0;
        cfg_pc_wr_gap = 4'd2;
        push_req(32'h40, 32'hB0, 1'b0); step();
        push_req(32'h50, 32'hB1, 1'b1); step();
        check("t3_first", cgra_cfg_g2f[0].addr, 66'h40);
        idle_inputs(); step();
        check("t3_idle1", cgra_cfg_g2f[0].wr_en, 66'd0);
        check("t3_busy1", pc_busy, 66'd1);
        step();
        check("t3_idle2", cgra_cfg_g2f[0].wr_en, 66'd0);
        step();
        check("t3_second", {cgra_cfg_g2f[0].wr_en, cgra_cfg_g2f[0].addr}, {1'b1, 32'h50});
        step();
        check("t3_busy_gap", pc_busy, 66'd1);
        step();
        check("t3_busy_end", pc_busy, 66'd0);

        // 4. JTAG held 4 cycles while the FIFO fills
        cfg_pc_wr_gap = 4'd0;
        jtag_cfg = '{rd_en: 1'b0, wr_en: 1'b1, addr: 32'hAB, data: 32'h0};
        push_req(32'h100, 32'hC0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) pc_req_addr = 32'h104;
            if (k == 2) pc_req_addr = 32'h108;
            step();
            check("t4_jtag", cgra_cfg_g2f[2], {2'b01, 32'hAB, 32'h0});
        end
        jtag_cfg = '0;
        step();
        check("t4_dma", {cgra_cfg_g2f[0].wr_en, cgra_cfg_g2f[0].addr}, {1'b1, 32'h100});
        idle_inputs();
        for (int k = 0; k < 3; k++) step();

        // 5. JTAG selection table
        for (int i = 0; i < 5; i++) begin
            jtag_cfg          = jv[i].jcfg;
            jtag_rd_en_bypass = jv[i].byp;
            jtag_addr_bypass  = jv[i].baddr;
            step();
            check("jtag_vec", cgra_cfg_g2f[1], jv[i].exp);
        end
        idle_inputs();

        // 6a. offset add and wrap table
        for (int i = 0; i < 4; i++) begin
            cfg_pc_offset = av[i].off;
            push_req(av[i].addr, 32'hD0 + 32'(i), 1'b1);
            step();
            idle_inputs();
            step();
            check("addr_vec", cgra_cfg_g2f[0].addr, 66'(av[i].exp));
            step();
        end

        // 6b. mode cleared with two entries pending
        cfg_pc_offset = 5'd0;
        jtag_cfg.wr_en = 1'b1;
        push_req(32'h200, 32'hE0, 1'b0); step();
        push_req(32'h210, 32'hE1, 1'b1); step();
        jtag_cfg = '0;
        cfg_pc_dma_mode = 1'b0;
        push_req(32'h220, 32'hE2, 1'b0);
        #1;
        check("t6_ready", pc_req_ready, 66'd0);
        step();
        check("t6_first", cgra_cfg_g2f[0].addr, 66'h200);
        step();
        check("t6_second", cgra_cfg_g2f[0].addr, 66'h210);
        check("t6_done", pc_done_pulse, 66'd1);
        idle_inputs();
        step();
        cfg_pc_dma_mode = 1'b1;

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            pc_req_valid    = ($urandom_range(0, 2) != 0);
            pc_req_addr     = $urandom;
            pc_req_data     = $urandom;
            pc_req_last     = ($urandom_range(0, 3) == 0);
            cfg_pc_dma_mode = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) cfg_pc_offset = 5'($urandom);
            if (n % 50 == 0) cfg_pc_wr_gap = 4'($urandom_range(0, 3));
            jtag_cfg          = '0;
            jtag_rd_en_bypass = 1'b0;
            case ($urandom_range(0, 9))
                0: begin
                    jtag_cfg.wr_en = 1'b1;
                    jtag_cfg.addr  = $urandom;
                    jtag_cfg.data  = $urandom;
                end
                1: begin
                    jtag_rd_en_bypass = 1'b1;
                    jtag_addr_bypass  = $urandom;
                    jtag_cfg.wr_en    = 1'($urandom_range(0, 1));
                end
                default: ;
            endcase
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/glb_tile_pcfg_sched.md
Name: glb_tile_pcfg_sched

Overview:
Per-tile parallel-configuration scheduler feeding the CGRA config fan-out of a global buffer tile. It merges two sources onto one registered config bus broadcast to all CGRA column outputs of the tile:
- the JTAG config path: no backpressure, highest priority, includes the read-address bypass;
- the DMA parallel-config stream: valid/ready handshake.

The DMA path applies the per-tile address offset and enforces a programmable inter-write gap. It also reports busy/done status for the DMA config sequence.

Parameters:
CGRA_PER_GLB, 4, number of CGRA column outputs driven by this tile
ADDR_W, 32, config address width (= CGRA_CFG_ADDR_WIDTH)
DATA_W, 32, config data width (= CGRA_CFG_DATA_WIDTH)
OFFSET_W, 5, width of cfg_pc_offset (= $clog2(NUM_CGRA_TILES))
GAP_W, 4, width of cfg_pc_wr_gap
CNT_W, 16, width of the PC write counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cfg_pc_dma_mode  in  1  enables acceptance of DMA config requests
cfg_pc_offset  in  OFFSET_W  added to every DMA config address
cfg_pc_wr_gap  in  GAP_W  idle cycles forced after each DMA issue
jtag_cfg  in  cgra_cfg_t  JTAG config packet (rd_en/wr_en/addr/data)
jtag_rd_en_bypass  in  1  JTAG read-bypass request
jtag_addr_bypass  in  ADDR_W  JTAG read-bypass address
pc_req_valid  in  1  DMA request valid
pc_req_ready  out  1  DMA request ready
pc_req_addr  in  ADDR_W  DMA config address
pc_req_data  in  DATA_W  DMA config data
pc_req_last  in  1  marks final request of a sequence
cgra_cfg_g2f  out  cgra_cfg_t [CGRA_PER_GLB]  registered config outputs
pc_busy  out  1  DMA entries pending or gap active
pc_done_pulse  out  1  one-cycle pulse when the last-flagged entry issues
pc_wr_cnt  out  CNT_W  DMA writes issued since the last pc_done_pulse

Behaviour:
- Reset (synchronous, when reset=1 at a clk edge):
  - all cgra_cfg_g2f fields = 0; pc_busy = 0; pc_done_pulse = 0; pc_wr_cnt = 0;
  - skid buffer empty; gap counter = 0; FSM in IDLE;
  - pc_req_ready = 0 during the reset cycle.
  - A reset in mid-sequence drops all pending entries. No partial output is emitted.
- Skid buffer:
  - 2-entry FIFO of {addr+offset, data, last}.
  - The address is computed at accept: addr + zero-extended offset, modulo 2^ADDR_W (wraps, no carry out).
  - pc_req_ready = cfg_pc_dma_mode & (count < 2).
  - Accept on valid & ready. Push and pop in the same cycle are legal; count is unchanged.
- JTAG source selection:
  - If jtag_rd_en_bypass=1: the JTAG packet is {rd_en=1, wr_en=0, addr=jtag_addr_bypass, data=0}.
  - Otherwise the JTAG packet is jtag_cfg.
  - The JTAG source is active when rd_en|wr_en of the selected packet is 1.
- Arbitration, evaluated each cycle:
  - JTAG active: the JTAG packet is issued; no DMA pop; the gap counter still decrements.
  - Otherwise, FIFO non-empty and gap==0: pop the head and issue {rd_en=0, wr_en=1, addr, data}.
  - Otherwise issue an all-zero packet.
- Output: the issued packet is registered, with 1-cycle latency. The same value goes to every cgra_cfg_g2f[i].
- FSM:
  - IDLE: no entries pending; goes to ISSUE on the first push.
  - ISSUE: on a DMA pop, load gap counter = cfg_pc_wr_gap. Go to GAP if cfg_pc_wr_gap != 0. Else stay in ISSUE if entries remain after the pop, else go to IDLE.
  - GAP: decrement each cycle. At 1 -> 0, go to ISSUE if entries remain, else IDLE.
  - pc_busy = (state != IDLE).
- Counters and done:
  - pc_wr_cnt increments on each DMA issue and saturates at all-ones.
  - When the popped entry has last=1: pc_done_pulse=1 in the same cycle the packet appears on cgra_cfg_g2f, and pc_wr_cnt clears to 0 on the following cycle.
- cfg_pc_dma_mode deasserted while entries are pending: new accepts stop, but pending entries still drain normally.
- Changing cfg_pc_offset mid-sequence affects only requests accepted afterwards.
- Simultaneous JTAG-active and FIFO-full: ready stays 0 until a DMA pop occurs. JTAG starvation of DMA is permitted by design.

Decomposition:
- global_buffer_pkg supplies:
  - cgra_cfg_t;
  - CGRA_PER_GLB, CGRA_CFG_ADDR_WIDTH, CGRA_CFG_DATA_WIDTH, NUM_CGRA_TILES;
  - a new enum pcfg_sched_state_e {IDLE, ISSUE, GAP}.
- One sub-module: glb_pcfg_skid_fifo, a 2-entry FIFO with synchronous reset and push/pop/count.

Test Plan:
1. Reset with pc_req_valid=1 -> ready=0 during reset; all outputs 0; one cycle after reset deasserts, ready=1 (mode=1).
2. mode=1, offset=3, gap=0, three requests addr=0x10/0x20/0x30 (last on third) -> g2f wr_en=1 addr=0x13/0x23/0x33 on three consecutive cycles; done pulse with the third; pc_wr_cnt=3 then 0.
3. gap=2, two requests -> issues separated by exactly 2 idle cycles; pc_busy=1 throughout, then 0.
4. JTAG wr_en=1 addr=0xAB held 4 cycles while FIFO is full -> 4 JTAG packets out, ready=0, no DMA issue; the DMA entry issues in the 5th output cycle.
5. jtag_rd_en_bypass=1 addr=0x55 with jtag_cfg wr_en=1 -> output {rd_en=1, wr_en=0, addr=0x55, data=0}.
6. offset=31 and addr=0xFFFFFFF0 -> output addr=0x0000000F (wrap). Separately: mode cleared with 2 pending entries -> both still issue, ready=0.
